gpio_f2m_debounce: RTL and testbench



---
 rtl/gpio_f2m_debounce.sv | 154 +++++++++++++++
 tb/tb_gpio_f2m_debounce.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gpio_f2m_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce FSM, press/release pulses and press counter.
// Define GPIO_F2M_LONG_PRESS_EN to build the long-press detector; otherwise LONG_PRESS is tied to 0.
module gpio_f2m_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1,
    parameter int EVT_W           = 8,
    parameter int LONG_CYCLES     = 50000000,
    parameter int LONG_W          = 26
) (
    input  logic             FAB_CCC_GL0,
    input  logic             FAB_RESET,
    input  logic             BTN_IN,
    output logic             GPIO_F2M,
    output logic             PRESS_PULSE,
    output logic             RELEASE_PULSE,
    output logic [EVT_W-1:0] PRESS_COUNT,
    output logic             LONG_PRESS
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_norm;
    logic             w_accept_press;
    logic             w_accept_release;
    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gpio;
    logic             r_press;
    logic             r_release;
    logic [EVT_W-1:0] r_count;

    assign w_btn_norm       = (ACTIVE_LOW != 0) ? ~BTN_IN : BTN_IN;
    assign w_accept_press   = (r_state == ARM_PRESS) && r_sync2 && (r_cnt == CNT_LAST);
    assign w_accept_release = (r_state == ARM_RELEASE) && !r_sync2 && (r_cnt == CNT_LAST);

    // Two-flop synchronizer; resets to "not pressed" so reset release cannot fake a press.
    always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_btn_norm;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce state machine with registered level, pulses and press counter.
    always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_gpio    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= '0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_state <= ARM_PRESS;
                        r_cnt   <= '0;
                    end
                end
                ARM_PRESS: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                    end else if (w_accept_press) begin
                        r_state <= PRESSED;
                        r_gpio  <= 1'b1;
                        r_press <= 1'b1;
                        r_count <= r_count + EVT_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= ARM_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                ARM_RELEASE: begin
                    if (r_sync2) begin
                        r_state <= PRESSED;
                    end else if (w_accept_release) begin
                        r_state   <= IDLE;
                        r_gpio    <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign GPIO_F2M      = r_gpio;
    assign PRESS_PULSE   = r_press;
    assign RELEASE_PULSE = r_release;
    assign PRESS_COUNT   = r_count;

`ifdef GPIO_F2M_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LCNT_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LCNT_PRE  = LONG_W'(LONG_CYCLES - 2);

    logic [LONG_W-1:0] r_lcnt;
    logic              r_long;

    // Hold-time counter; restarts only on a fresh accepted press, not on a release bounce.
    always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else if (w_accept_press) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else if (w_accept_release) begin
            r_long <= 1'b0;
        end else if ((r_state == PRESSED) || (r_state == ARM_RELEASE)) begin
            if (r_lcnt != LCNT_LAST) begin
                r_lcnt <= r_lcnt + LONG_W'(1);
            end
            if (r_lcnt == LCNT_PRE) begin
                r_long <= 1'b1;
            end
        end else begin
            r_long <= r_long;
        end
    end

    assign LONG_PRESS = r_long;
`else
    logic [31:0] w_unused_long;
    assign w_unused_long = 32'(LONG_CYCLES) ^ 32'(LONG_W);
    assign LONG_PRESS    = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_f2m_debounce.sv
// Bench for gpio_f2m_debounce: expected pulses are queued when stimulus is driven and
// compared cycle by cycle against the DUT outputs.
module tb_gpio_f2m_debounce;

    localparam int D  = 4;
    localparam int CW = 3;
    localparam int EW = 2;
    localparam int L  = 10;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn = 1'b1;
    logic          gpio;
    logic          ppulse;
    logic          rpulse;
    logic [EW-1:0] pcount;
    logic          lpress;

    gpio_f2m_debounce #(
        .DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW(1), .EVT_W(EW),
        .LONG_CYCLES(L), .LONG_W(LW)
    ) dut (
        .FAB_CCC_GL0(clk), .FAB_RESET(rst), .BTN_IN(btn), .GPIO_F2M(gpio),
        .PRESS_PULSE(ppulse), .RELEASE_PULSE(rpulse), .PRESS_COUNT(pcount),
        .LONG_PRESS(lpress)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            rel;
        int            at;
        logic [EW-1:0] cnt;
    } ev_t;

    ev_t           q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mdl_press = 1'b0;
    logic [EW-1:0] sb_cnt = '0;
    logic          exp_gpio = 1'b0;
    logic [EW-1:0] exp_cnt = '0;
    logic          exp_long = 1'b0;
    int            press_at = 0;
    bit            ep;
    bit            er;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Per-cycle scoreboard: pop an event when its cycle arrives, then compare every output.
    always @(negedge clk) begin
        ep = 1'b0;
        er = 1'b0;
        if (q.size() > 0 && q[0].at < cyc) begin
            chk("missed_event", 32'(q[0].at), 32'(cyc));
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            ep = !q[0].rel;
            er = q[0].rel;
        end
        if (ep) begin
            exp_gpio = 1'b1;
            exp_cnt  = q[0].cnt;
            press_at = cyc;
        end
`ifdef GPIO_F2M_LONG_PRESS_EN
        if (exp_gpio && !ep && !er && (cyc - press_at == L - 1)) exp_long = 1'b1;
`endif
        if (er) begin
            exp_gpio = 1'b0;
            exp_long = 1'b0;
        end
        if (ep || er) void'(q.pop_front());
        chk("press_pulse", 32'(ppulse), 32'(ep));
        chk("release_pulse", 32'(rpulse), 32'(er));
        chk("gpio_f2m", 32'(gpio), 32'(exp_gpio));
        chk("press_count", 32'(pcount), 32'(exp_cnt));
        chk("long_press", 32'(lpress), 32'(exp_long));
    end

    // Drive the pad for n edges; a level change held at least D+1 edges is accepted D+3 edges later.
    task automatic hold(input bit pressed, input int n);
        ev_t e;
        @(negedge clk);
        btn = pressed ? 1'b0 : 1'b1;
        if (pressed != mdl_press && n >= D + 1) begin
            mdl_press = pressed;
            if (pressed) sb_cnt = sb_cnt + 2'd1;
            e.rel = !pressed;
            e.at  = cyc + D + 3;
            e.cnt = sb_cnt;
            q.push_back(e);
        end
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 50);

        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 4);
        end
        hold(1'b1, 4);
        hold(1'b0, 6);

        hold(1'b1, 8);
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 3);
            hold(1'b1, 4);
        end
        hold(1'b0, 8);

        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 8);
            hold(1'b0, 9);
        end

        hold(1'b1, 5);
        hold(1'b0, 5);
        hold(1'b1, 20);
        hold(1'b0, 10);

        hold(1'b1, 10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        btn = 1'b1;
        #1;
        chk("rst_gpio", 32'(gpio), 32'd0);
        chk("rst_release", 32'(rpulse), 32'd0);
        chk("rst_count", 32'(pcount), 32'd0);
        chk("rst_long", 32'(lpress), 32'd0);
        q.delete();
        mdl_press = 1'b0;
        sb_cnt    = '0;
        exp_gpio  = 1'b0;
        exp_cnt   = '0;
        exp_long  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 5);
        hold(1'b1, 9);
        hold(1'b0, 10);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
